// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Contents: FSM state enum, digit-count and counter-width helpers.
// Imported by serial_sub and sub_digit.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Number of digit cycles needed to cover the full operand width.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width for n cycles; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: d = x - y - bi, bo = borrow out.
// Ports: x, y (DIGIT-bit operands), bi (borrow in) -> d (difference), bo.
// Purely combinational; no clock or reset.
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] brw;

  always_comb begin
    brw    = '0;
    d      = '0;
    brw[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]     = x[i] ^ y[i] ^ brw[i];
      // Borrow when x < y, or when the bits match and a borrow is pending.
      brw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
    end
    bo = brw[DIGIT];
  end

endmodule

// File: rtl/serial_sub.sv
// Digit-serial unsigned subtractor: z = a - b - bin over WIDTH/DIGIT cycles.
// Ports: clk, reset (sync, active-high), start/a/b/bin in; busy, done, z, bout out.
// Optional macro SERIAL_SUB_OVF_EN adds output ovf (signed overflow, registered with z).
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = cnt_w(N);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_sub: WIDTH must be a multiple of DIGIT");
  end

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] dig_d;
  logic             dig_bo;
  logic [WIDTH-1:0] res_shift;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .bi (brw_q),
    .d  (dig_d),
    .bo (dig_bo)
  );

  // New slice enters from the MSB side so that after N shifts the first
  // (least significant) slice has reached bit 0.
  assign res_shift = (WIDTH'(dig_d) << (WIDTH - DIGIT)) | (res_q >> DIGIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    z_d     = z_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = dig_bo;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          z_d     = res_shift;
          bout_d  = dig_bo;
`ifdef SERIAL_SUB_OVF_EN
          // On the last digit the operand registers hold the sign digits.
          ovf_d   = (a_q[DIGIT-1] ^ b_q[DIGIT-1]) & (dig_d[DIGIT-1] != a_q[DIGIT-1]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      z_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      z_q     <= z_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=16, DIGIT=4).
// Scenario tasks compare DUT outputs to an arithmetic reference model.
// Build with SERIAL_SUB_OVF_EN defined to also exercise ovf.
module tb_serial_sub;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] z;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int passed = 0;

  serial_sub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_z(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int d;
    logic [31:0] dv;
    d  = int'(x) - int'(y) - int'(bi);
    dv = d;
    return dv[W-1:0];
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    return (int'(x) < int'(y) + int'(bi));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int r;
    r = int'($signed(x)) - int'($signed(y)) - int'(bi);
    return (r > 32767) || (r < -32768);
  endfunction

  // Present a request for one cycle, then scramble the inputs so that
  // only the accepting edge can have been used.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    start = 1'b1;
    a = x;
    b = y;
    bin = bi;
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  // Bounded wait for done; counts busy cycles seen on the way.
  task automatic wait_done(output int busy_cycles, output bit found);
    busy_cycles = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (done === 1'b1) found = 1'b1;
      else begin
        if (busy === 1'b1) busy_cycles++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({busy, done, bout, z} !== {1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_state: busy=%b done=%b bout=%b z=%h, want all zero", busy, done, bout, z);
    else passed++;
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: ovf=%b want 0", ovf);
    else passed++;
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input string nm);
    int  bc;
    bit  f;
    logic [W-1:0] ez;
    logic eb;
    ez = ref_z(x, y, bi);
    eb = ref_bout(x, y, bi);
    launch(x, y, bi);
    wait_done(bc, f);
    total++;
    if (!f) $display("FAIL %s_timeout: done never seen, want done within bound", nm);
    else passed++;
    total++;
    if (bc !== N) $display("FAIL %s_busy_cycles: got %0d want %0d", nm, bc, N);
    else passed++;
    total++;
    if ({z, bout} !== {ez, eb}) $display("FAIL %s_result: z=%h bout=%b want z=%h bout=%b", nm, z, bout, ez, eb);
    else passed++;
    step();
    total++;
    if ({done, busy, z, bout} !== {1'b0, 1'b0, ez, eb})
      $display("FAIL %s_after: done=%b busy=%b z=%h bout=%b want 0 0 %h %b", nm, done, busy, z, bout, ez, eb);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int bc;
    bit f;
    launch(16'd12, 16'd2, 1'b0);
    wait_done(bc, f);
    total++;
    if (!f || z !== 16'd10 || bout !== 1'b0) $display("FAIL b2b_first: found=%b z=%h bout=%b want z=000a bout=0", f, z, bout);
    else passed++;
    // Still in the done cycle: request the next operation immediately.
    launch(16'd16, 16'd9, 1'b1);
    wait_done(bc, f);
    total++;
    if (!f || bc !== N) $display("FAIL b2b_latency: found=%b busy_cycles=%0d want %0d", f, bc, N);
    else passed++;
    total++;
    if (z !== 16'd6 || bout !== 1'b0) $display("FAIL b2b_second: z=%h bout=%b want z=0006 bout=0", z, bout);
    else passed++;
    step();
  endtask

  task automatic test_start_while_busy();
    int pulses;
    launch(16'h0123, 16'h0045, 1'b0);
    // Hammer start with other operands during RUN; must be ignored.
    start = 1'b1; a = 16'd2; b = 16'd8; bin = 1'b0;
    step();
    step();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) begin
        pulses++;
        total++;
        if (z !== ref_z(16'h0123, 16'h0045, 1'b0) || bout !== 1'b0)
          $display("FAIL busy_ignore_result: z=%h bout=%b want z=%h bout=0", z, bout, ref_z(16'h0123, 16'h0045, 1'b0));
        else passed++;
      end
      step();
    end
    total++;
    if (pulses !== 1) $display("FAIL busy_ignore_pulses: got %0d done pulses want 1", pulses);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    launch(16'h1234, 16'h0FFF, 1'b1);
    step();  // now in second RUN cycle
    reset = 1'b1;
    step();
    total++;
    if ({busy, done, bout, z} !== {1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL midrun_reset: busy=%b done=%b bout=%b z=%h want all zero", busy, done, bout, z);
    else passed++;
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      step();
    end
    total++;
    if (pulses !== 0) $display("FAIL midrun_no_done: got %0d active cycles want 0", pulses);
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic bi;
    int bc;
    bit f;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      bi = 1'($urandom);
      if (i % 5 == 0) y = x;  // exercise the equal-operand borrow edge
      launch(x, y, bi);
      wait_done(bc, f);
      total++;
      if (!f || z !== ref_z(x, y, bi) || bout !== ref_bout(x, y, bi))
        $display("FAIL random_%0d: a=%h b=%h bin=%b found=%b z=%h bout=%b want z=%h bout=%b",
                 i, x, y, bi, f, z, bout, ref_z(x, y, bi), ref_bout(x, y, bi));
      else passed++;
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ovf !== ref_ovf(x, y, bi))
        $display("FAIL random_ovf_%0d: a=%h b=%h bin=%b ovf=%b want %b", i, x, y, bi, ovf, ref_ovf(x, y, bi));
      else passed++;
`endif
      if ($urandom_range(1, 0) == 1) step();
    end
    step();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic want, input string nm);
    int bc;
    bit f;
    launch(x, y, 1'b0);
    wait_done(bc, f);
    total++;
    if (!f || ovf !== want || z !== ref_z(x, y, 1'b0) || bout !== ref_bout(x, y, 1'b0))
      $display("FAIL %s: found=%b ovf=%b z=%h bout=%b want ovf=%b z=%h bout=%b",
               nm, f, ovf, z, bout, want, ref_z(x, y, 1'b0), ref_bout(x, y, 1'b0));
    else passed++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic(16'h000A, 16'h000B, 1'b0, "a_lt_b");
    test_basic(16'h0000, 16'h0000, 1'b1, "wrap_bin");
    test_basic(16'hFFFF, 16'hFFFF, 1'b0, "equal_max");
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf(16'h8000, 16'h0001, 1'b1, "ovf_neg_min");
    test_ovf(16'h0005, 16'h0003, 1'b0, "ovf_small");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
